// File: rtl/enemy_pkg.sv
// Enemy slot state encoding and lane geometry helper.
package enemy_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FLY       = 2'd1,
      DESTROYED = 2'd2,
      BREACH    = 2'd3
   } slot_state_t;

   localparam int unsigned CNT_W = 4;

   function automatic int unsigned lane_y(input int unsigned idx,
                                          input int unsigned base,
                                          input int unsigned step);
      return base + idx * step;
   endfunction

endpackage

// File: rtl/img_pkg.sv
// Sprite ROM layout constants shared by the sprite consumers.
package img_pkg;

   localparam int unsigned ADR_EXPLOSION_START = 32'h0000_0800;

endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: flight FSM, x position and explosion countdown.
module enemy_slot
   import enemy_pkg::*;
   import img_pkg::*;
#(
   parameter int unsigned OUT_WIDTH     = 8,
   parameter int unsigned ADDRESSWIDTH  = 12,
   parameter int unsigned X_START       = 240,
   parameter int unsigned X_END         = 16,
   parameter int unsigned STEP          = 1,
   parameter int unsigned DESTROY_TIME  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    alloc,
   input  logic                    hit,
   input  logic                    speed_pulse,
   input  logic [ADDRESSWIDTH-1:0] adr_start,
   output logic [OUT_WIDTH-1:0]    x,
   output logic                    spawn,
   output logic [ADDRESSWIDTH-1:0] adr,
   output logic                    hit_evt,
   output logic                    breach_evt,
   output logic                    is_idle,
   output logic                    is_fly
);

   localparam int unsigned XW = OUT_WIDTH + 1;
   localparam logic [OUT_WIDTH-1:0]    X_START_V = OUT_WIDTH'(X_START);
   localparam logic [OUT_WIDTH-1:0]    X_END_V   = OUT_WIDTH'(X_END);
   localparam logic [OUT_WIDTH-1:0]    STEP_V    = OUT_WIDTH'(STEP);
   localparam logic [CNT_W-1:0]        DT_V      = CNT_W'(DESTROY_TIME);
   localparam logic [ADDRESSWIDTH-1:0] ADR_EXPL  = ADDRESSWIDTH'(ADR_EXPLOSION_START);

   slot_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [XW-1:0]    x_room;

   // Distance left to the base line; a step larger than this saturates.
   assign x_room     = {1'b0, x} - {1'b0, X_END_V};
   assign is_idle    = (state == IDLE);
   assign is_fly     = (state == FLY);
   assign hit_evt    = en && is_fly && hit;
   assign breach_evt = en && is_fly && !hit && (x == X_END_V);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         x     <= X_START_V;
         spawn <= 1'b0;
         adr   <= adr_start;
         cnt   <= '0;
      end else if (en) begin
         case (state)
            IDLE: begin
               x     <= X_START_V;
               spawn <= 1'b0;
               if (alloc) begin
                  state <= FLY;
                  spawn <= 1'b1;
                  adr   <= adr_start;
               end
            end
            FLY: begin
               if (hit) begin
                  state <= DESTROYED;
                  cnt   <= DT_V;
                  adr   <= ADR_EXPL;
               end else if (x == X_END_V) begin
                  state <= BREACH;
                  spawn <= 1'b0;
               end else if (speed_pulse) begin
                  if (x_room < XW'(STEP_V)) x <= X_END_V;
                  else                      x <= x - STEP_V;
               end
            end
            DESTROYED: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  spawn <= 1'b0;
                  x     <= X_START_V;
                  adr   <= adr_start;
               end else if (speed_pulse) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               x     <= X_START_V;
               spawn <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/enemy_wave_control.sv
// Multi-slot enemy wave controller: spawn allocation, per-slot flight and event reporting.
module enemy_wave_control
   import enemy_pkg::*;
#(
   parameter int unsigned N_ENEMY       = 4,
   parameter int unsigned OUT_WIDTH     = 8,
   parameter int unsigned ADDRESSWIDTH  = 12,
   parameter int unsigned X_ENEMY_START = 240,
   parameter int unsigned X_ENEMY_END   = 16,
   parameter int unsigned STEP          = 1,
   parameter int unsigned Y_LANE_BASE   = 32,
   parameter int unsigned Y_LANE_STEP   = 40,
   parameter int unsigned DESTROY_TIME  = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic                              speed_pulse,
   input  logic                              spawn_pulse,
   input  logic [ADDRESSWIDTH-1:0]           adr_enemy_start,
   input  logic [N_ENEMY-1:0]                rockethit,
   output logic [N_ENEMY*OUT_WIDTH-1:0]      xenemy,
   output logic [N_ENEMY*OUT_WIDTH-1:0]      yenemy,
   output logic [N_ENEMY-1:0]                spawn,
   output logic [N_ENEMY*ADDRESSWIDTH-1:0]   adr_enemy,
   output logic                              kill_pulse,
   output logic                              breach_pulse,
   output logic                              spawn_drop,
   output logic [$clog2(N_ENEMY+1)-1:0]      alive_count
);

   localparam int unsigned CW = $clog2(N_ENEMY + 1);

   logic [N_ENEMY-1:0] alloc;
   logic [N_ENEMY-1:0] hit_evt;
   logic [N_ENEMY-1:0] breach_evt;
   logic [N_ENEMY-1:0] is_idle;
   logic [N_ENEMY-1:0] is_fly;
   logic               found;
   logic [CW-1:0]      alive_nxt;

   for (genvar g = 0; g < N_ENEMY; g++) begin : g_slot
      enemy_slot #(
         .OUT_WIDTH    (OUT_WIDTH),
         .ADDRESSWIDTH (ADDRESSWIDTH),
         .X_START      (X_ENEMY_START),
         .X_END        (X_ENEMY_END),
         .STEP         (STEP),
         .DESTROY_TIME (DESTROY_TIME)
      ) u_slot (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .alloc       (alloc[g]),
         .hit         (rockethit[g]),
         .speed_pulse (speed_pulse),
         .adr_start   (adr_enemy_start),
         .x           (xenemy[g*OUT_WIDTH +: OUT_WIDTH]),
         .spawn       (spawn[g]),
         .adr         (adr_enemy[g*ADDRESSWIDTH +: ADDRESSWIDTH]),
         .hit_evt     (hit_evt[g]),
         .breach_evt  (breach_evt[g]),
         .is_idle     (is_idle[g]),
         .is_fly      (is_fly[g])
      );
      assign yenemy[g*OUT_WIDTH +: OUT_WIDTH] =
         OUT_WIDTH'(lane_y(g, Y_LANE_BASE, Y_LANE_STEP));
   end

   // Lowest-index idle slot takes the spawn request.
   always_comb begin
      alloc = '0;
      found = 1'b0;
      for (int i = 0; i < N_ENEMY; i++) begin
         if (!found && is_idle[i]) begin
            alloc[i] = en && spawn_pulse;
            found    = 1'b1;
         end
      end
   end

   // Population after this edge: current flyers plus new spawns minus departures.
   always_comb begin
      alive_nxt = '0;
      for (int i = 0; i < N_ENEMY; i++) begin
         if ((is_fly[i] && !hit_evt[i] && !breach_evt[i]) || alloc[i])
            alive_nxt = alive_nxt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kill_pulse   <= 1'b0;
         breach_pulse <= 1'b0;
         spawn_drop   <= 1'b0;
         alive_count  <= '0;
      end else begin
         kill_pulse   <= en && (|hit_evt);
         breach_pulse <= en && (|breach_evt);
         spawn_drop   <= en && spawn_pulse && !(|is_idle);
         if (en) alive_count <= alive_nxt;
      end
   end

endmodule

// File: tb/tb_enemy_wave_control.sv
// Directed self-checking bench for enemy_wave_control.
module tb_enemy_wave_control;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        speed_pulse;
   logic        spawn_pulse;
   logic [11:0] adr_start;
   logic [3:0]  rockethit;

   logic [31:0] xenemy, yenemy, xs3, ys3;
   logic [3:0]  spawn, spawn3;
   logic [47:0] adr_enemy, adr3;
   logic        kill_pulse, breach_pulse, spawn_drop;
   logic        kill3, breach3, drop3;
   logic [2:0]  alive_count, alive3;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [11:0] EXPL = 12'h800;

   always #5 clk = ~clk;

   enemy_wave_control dut (
      .clk(clk), .rst(rst), .en(en), .speed_pulse(speed_pulse),
      .spawn_pulse(spawn_pulse), .adr_enemy_start(adr_start), .rockethit(rockethit),
      .xenemy(xenemy), .yenemy(yenemy), .spawn(spawn), .adr_enemy(adr_enemy),
      .kill_pulse(kill_pulse), .breach_pulse(breach_pulse), .spawn_drop(spawn_drop),
      .alive_count(alive_count)
   );

   enemy_wave_control #(.STEP(3)) dut_s3 (
      .clk(clk), .rst(rst), .en(en), .speed_pulse(speed_pulse),
      .spawn_pulse(spawn_pulse), .adr_enemy_start(adr_start), .rockethit(rockethit),
      .xenemy(xs3), .yenemy(ys3), .spawn(spawn3), .adr_enemy(adr3),
      .kill_pulse(kill3), .breach_pulse(breach3), .spawn_drop(drop3),
      .alive_count(alive3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs for one clock edge, then return 1 time unit after it.
   task automatic step(input logic sp, input logic sw, input logic [3:0] h);
      speed_pulse = sp;
      spawn_pulse = sw;
      rockethit   = h;
      @(posedge clk);
      #1;
      speed_pulse = 1'b0;
      spawn_pulse = 1'b0;
      rockethit   = 4'b0000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, 4'b0000);
      step(1'b0, 1'b0, 4'b0000);
      rst = 1'b0;
   endtask

   function automatic logic [7:0] xs(input logic [31:0] v, input int i);
      return v[i*8 +: 8];
   endfunction

   function automatic logic [11:0] as(input logic [47:0] v, input int i);
      return v[i*12 +: 12];
   endfunction

   initial begin
      rst = 1'b1; en = 1'b1; speed_pulse = 1'b0; spawn_pulse = 1'b0;
      rockethit = 4'b0000; adr_start = 12'h123;
      @(posedge clk); #1;
      do_reset();

      // Reset state
      chk("rst_spawn", 64'(spawn), 64'h0);
      chk("rst_alive", 64'(alive_count), 64'd0);
      chk("rst_x", 64'(xenemy), 64'hF0F0_F0F0);
      chk("rst_y", 64'(yenemy), {32'h0, 8'd152, 8'd112, 8'd72, 8'd32});
      chk("rst_adr", 64'(adr_enemy), 64'h123_123_123_123);
      chk("rst_pulses", 64'({kill_pulse, breach_pulse, spawn_drop}), 64'h0);

      // Allocation in slot order, then a dropped spawn
      step(1'b0, 1'b1, 4'b0000);
      chk("sp1_spawn", 64'(spawn), 64'b0001);
      chk("sp1_x0", 64'(xs(xenemy, 0)), 64'd240);
      chk("sp1_adr0", 64'(as(adr_enemy, 0)), 64'h123);
      chk("sp1_alive", 64'(alive_count), 64'd1);
      step(1'b0, 1'b1, 4'b0000);
      chk("sp2_spawn", 64'(spawn), 64'b0011);
      adr_start = 12'h456;
      step(1'b0, 1'b1, 4'b0000);
      chk("sp3_spawn", 64'(spawn), 64'b0111);
      chk("sp3_adr2", 64'(as(adr_enemy, 2)), 64'h456);
      step(1'b0, 1'b1, 4'b0000);
      chk("sp4_spawn", 64'(spawn), 64'b1111);
      chk("sp4_alive", 64'(alive_count), 64'd4);
      chk("sp4_drop", 64'(spawn_drop), 64'd0);
      step(1'b0, 1'b1, 4'b0000);
      chk("sp5_drop", 64'(spawn_drop), 64'd1);
      chk("sp5_spawn", 64'(spawn), 64'b1111);
      chk("sp5_alive", 64'(alive_count), 64'd4);
      step(1'b0, 1'b0, 4'b0000);
      chk("sp6_drop", 64'(spawn_drop), 64'd0);

      // Double hit gives a single kill pulse
      step(1'b0, 1'b0, 4'b0011);
      chk("hit2_kill", 64'(kill_pulse), 64'd1);
      chk("hit2_alive", 64'(alive_count), 64'd2);
      chk("hit2_spawn", 64'(spawn), 64'b1111);
      chk("hit2_adr0", 64'(as(adr_enemy, 0)), 64'(EXPL));
      step(1'b0, 1'b0, 4'b0000);
      chk("hit2_kill_off", 64'(kill_pulse), 64'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0000);
      chk("expl_still_vis", 64'(spawn), 64'b1111);
      chk("expl_x2", 64'(xs(xenemy, 2)), 64'd237);
      chk("expl_x0_frozen", 64'(xs(xenemy, 0)), 64'd240);
      step(1'b0, 1'b0, 4'b0000);
      chk("expl_done_spawn", 64'(spawn), 64'b1100);
      chk("expl_done_adr0", 64'(as(adr_enemy, 0)), 64'h456);

      // Breach of slot 1; STEP=3 instance checks saturation
      do_reset();
      adr_start = 12'h123;
      step(1'b0, 1'b1, 4'b0000);
      step(1'b0, 1'b1, 4'b0000);
      step(1'b0, 1'b0, 4'b0001);
      for (int i = 0; i < 74; i++) step(1'b1, 1'b0, 4'b0000);
      chk("s3_x1_18", 64'(xs(xs3, 1)), 64'd18);
      chk("s1_x1_166", 64'(xs(xenemy, 1)), 64'd166);
      step(1'b1, 1'b0, 4'b0000);
      chk("s3_x1_sat", 64'(xs(xs3, 1)), 64'd16);
      for (int i = 0; i < 149; i++) step(1'b1, 1'b0, 4'b0000);
      chk("brc_x1_16", 64'(xs(xenemy, 1)), 64'd16);
      chk("brc_pre_spawn", 64'(spawn), 64'b0010);
      chk("brc_pre_pulse", 64'(breach_pulse), 64'd0);
      step(1'b0, 1'b0, 4'b0000);
      chk("brc_pulse", 64'(breach_pulse), 64'd1);
      chk("brc_spawn", 64'(spawn), 64'b0000);
      chk("brc_x1", 64'(xs(xenemy, 1)), 64'd16);
      chk("brc_alive", 64'(alive_count), 64'd0);
      step(1'b0, 1'b0, 4'b0000);
      chk("brc_pulse_off", 64'(breach_pulse), 64'd0);
      chk("brc_idle_x1", 64'(xs(xenemy, 1)), 64'd240);

      // Hit on the same cycle the slot sits at the base line
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0000);
      chk("hx_alive3", 64'(alive_count), 64'd3);
      step(1'b0, 1'b0, 4'b0011);
      for (int i = 0; i < 224; i++) step(1'b1, 1'b0, 4'b0000);
      chk("hx_x2_16", 64'(xs(xenemy, 2)), 64'd16);
      chk("hx_alive1", 64'(alive_count), 64'd1);
      step(1'b0, 1'b0, 4'b0100);
      chk("hx_kill", 64'(kill_pulse), 64'd1);
      chk("hx_no_breach", 64'(breach_pulse), 64'd0);
      chk("hx_adr2", 64'(as(adr_enemy, 2)), 64'(EXPL));
      chk("hx_spawn", 64'(spawn), 64'b0100);
      chk("hx_alive0", 64'(alive_count), 64'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0000);
      step(1'b0, 1'b0, 4'b0000);
      chk("hx_done_spawn", 64'(spawn), 64'b0000);
      chk("hx_done_adr2", 64'(as(adr_enemy, 2)), 64'h123);
      chk("hx_breach_never", 64'(breach_pulse), 64'd0);

      // Freeze while en is low, then reset from DESTROYED
      do_reset();
      step(1'b0, 1'b1, 4'b0000);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'b0000);
      chk("en_x0_230", 64'(xs(xenemy, 0)), 64'd230);
      en = 1'b0;
      for (int i = 0; i < 50; i++) step(1'b1, (i == 25), 4'b0000);
      chk("en_x0_frozen", 64'(xs(xenemy, 0)), 64'd230);
      chk("en_spawn_hold", 64'(spawn), 64'b0001);
      chk("en_alive", 64'(alive_count), 64'd1);
      chk("en_pulses", 64'({kill_pulse, breach_pulse, spawn_drop}), 64'h0);
      step(1'b0, 1'b0, 4'b0001);
      chk("en_hit_ignored", 64'(kill_pulse), 64'd0);
      en = 1'b1;
      step(1'b0, 1'b0, 4'b0001);
      chk("rd_kill", 64'(kill_pulse), 64'd1);
      rst = 1'b1;
      step(1'b0, 1'b0, 4'b0000);
      rst = 1'b0;
      chk("rd_spawn", 64'(spawn), 64'b0000);
      chk("rd_x0", 64'(xs(xenemy, 0)), 64'd240);
      chk("rd_alive", 64'(alive_count), 64'd0);
      chk("rd_kill_off", 64'(kill_pulse), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
